// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receive engine: 16x oversampled, 5-8 data bits, optional parity, 1-2 stop bits
module uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sample_tick,
    input  logic       rx,
    input  logic [1:0] data_bits_count,
    input  logic [1:0] parity_type,
    input  logic       double_stop_bits,
    output logic [7:0] dout,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err
);
    localparam int CW = $clog2(OVERSAMPLE);
    // Start bit is confirmed on the tick that brings the counter to OVERSAMPLE/2-1.
    localparam logic [CW-1:0] MID  = CW'(OVERSAMPLE / 2 - 2);
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_HIGH} state_t;

    state_t        state;
    logic          rx_meta;
    logic          rxs;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_acc;
    logic          perr_acc;
    logic          ferr_acc;
    logic [1:0]    cfg_dbc;
    logic [1:0]    cfg_pt;
    logic          cfg_ds;
    logic          par_en;
    logic          sample_now;

    assign par_en     = cfg_pt[0] ^ cfg_pt[1];
    assign sample_now = sample_tick && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta    <= 1'b1;
            rxs        <= 1'b1;
            state      <= IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_acc    <= 1'b0;
            perr_acc   <= 1'b0;
            ferr_acc   <= 1'b0;
            cfg_dbc    <= '0;
            cfg_pt     <= '0;
            cfg_ds     <= 1'b0;
            dout       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            valid   <= 1'b0;
            case (state)
                IDLE: begin
                    if (sample_tick && !rxs) begin
                        cnt      <= '0;
                        bit_cnt  <= '0;
                        shreg    <= '0;
                        par_acc  <= 1'b0;
                        perr_acc <= 1'b0;
                        ferr_acc <= 1'b0;
                        cfg_dbc  <= data_bits_count;
                        cfg_pt   <= parity_type;
                        cfg_ds   <= double_stop_bits;
                        state    <= START;
                    end
                end
                START: begin
                    if (sample_tick) begin
                        if (cnt == MID) begin
                            cnt   <= '0;
                            state <= rxs ? IDLE : DATA;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (sample_tick) cnt <= cnt + 1'b1;
                    if (sample_now) begin
                        shreg   <= {rxs, shreg[7:1]};
                        par_acc <= par_acc ^ rxs;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == {1'b0, cfg_dbc} + 3'd4)
                            state <= par_en ? PARITY : STOP1;
                    end
                end
                PARITY: begin
                    if (sample_tick) cnt <= cnt + 1'b1;
                    if (sample_now) begin
                        // Odd mode (cfg_pt[1]=1) flags an error when the overall XOR is 0.
                        perr_acc <= par_acc ^ rxs ^ cfg_pt[1];
                        state    <= STOP1;
                    end
                end
                STOP1, STOP2: begin
                    if (sample_tick) cnt <= cnt + 1'b1;
                    if (sample_now) begin
                        ferr_acc <= ferr_acc | ~rxs;
                        if (state == STOP1 && cfg_ds) begin
                            state <= STOP2;
                        end else begin
                            valid      <= 1'b1;
                            dout       <= shreg >> (2'd3 - cfg_dbc);
                            parity_err <= perr_acc;
                            frame_err  <= ferr_acc | ~rxs;
                            state      <= rxs ? IDLE : WAIT_HIGH;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (sample_tick && rxs) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx against a frame-level expectation model
module tb_uart_rx;
    logic       clk = 1'b0;
    logic       reset;
    logic       sample_tick;
    logic       rx;
    logic [1:0] data_bits_count;
    logic [1:0] parity_type;
    logic       double_stop_bits;
    logic [7:0] dout;
    logic       valid;
    logic       parity_err;
    logic       frame_err;

    uart_rx #(.OVERSAMPLE(16)) dut (
        .clk(clk), .reset(reset), .sample_tick(sample_tick), .rx(rx),
        .data_bits_count(data_bits_count), .parity_type(parity_type),
        .double_stop_bits(double_stop_bits), .dout(dout), .valid(valid),
        .parity_err(parity_err), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   tick_no = 0;
    int   last_d0 = 0;
    int   dut_valid_tick = -1;
    logic last_tick = 1'b0;
    logic last_reset = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(posedge clk) begin
        if (sample_tick) tick_no <= tick_no + 1;
        last_tick  <= sample_tick;
        last_reset <= reset;
    end

    // Per-cycle compare: valid only in the cycle after the tick that samples the last stop bit,
    // outputs hold the most recent expected character otherwise.
    initial begin
        logic [7:0] hold_d;
        logic       hold_pe;
        logic       hold_fe;
        logic       exp_v;
        hold_d = 8'h00; hold_pe = 1'b0; hold_fe = 1'b0;
        forever begin
            @(negedge clk);
            exp_v = 1'b0;
            if (last_reset) begin
                hold_d = 8'h00; hold_pe = 1'b0; hold_fe = 1'b0;
            end else if (q.size() > 0 && last_tick && q[0].due == tick_no) begin
                exp_v   = 1'b1;
                hold_d  = q[0].d;
                hold_pe = q[0].pe;
                hold_fe = q[0].fe;
                void'(q.pop_front());
            end
            if (valid) dut_valid_tick = tick_no;
            chk("valid", {31'd0, valid}, {31'd0, exp_v});
            chk("dout", {24'd0, dout}, {24'd0, hold_d});
            chk("parity_err", {31'd0, parity_err}, {31'd0, hold_pe});
            chk("frame_err", {31'd0, frame_err}, {31'd0, hold_fe});
            if (q.size() > 0 && tick_no > q[0].due) begin
                chk("missing_valid_tick", tick_no, q[0].due);
                void'(q.pop_front());
            end
        end
    end

    task automatic do_tick();
        repeat ($urandom_range(2, 3)) @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (16) do_tick();
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) do_tick();
    endtask

    // mode 0: normal, 1: change data_bits_count during data bit 3, 2: reset during data bit 3
    task automatic send_frame(input logic [7:0] data, input int n, input logic [1:0] pt,
                              input logic ds, input logic pflip, input logic s1_low,
                              input logic s2_low, input int mode);
        exp_t       e;
        logic [7:0] m;
        logic       pen;
        logic       pbit;
        m   = data & 8'((1 << n) - 1);
        pen = (pt == 2'b01) || (pt == 2'b10);
        pbit = ((pt == 2'b10) ? ~(^m) : (^m)) ^ pflip;
        data_bits_count  = 2'(n - 5);
        parity_type      = pt;
        double_stop_bits = ds;
        last_d0 = tick_no + 1;
        e.due = last_d0 + 7 + 16 * (n + int'(pen) + 1 + int'(ds));
        e.d   = m;
        e.pe  = pen & pflip;
        e.fe  = s1_low | (ds & s2_low);
        if (mode != 2) q.push_back(e);
        send_bit(1'b0);
        for (int i = 0; i < n; i++) begin
            if (i == 3 && mode == 1) data_bits_count = 2'd0;
            if (i == 3 && mode == 2) begin
                rx = m[3];
                repeat (8) do_tick();
                rx = 1'b1;
                reset = 1'b1;
                repeat (3) @(negedge clk);
                chk("reset_mid_dout", {24'd0, dout}, 32'd0);
                chk("reset_mid_valid", {31'd0, valid}, 32'd0);
                reset = 1'b0;
                return;
            end
            send_bit(m[i]);
        end
        if (pen) send_bit(pbit);
        send_bit(~s1_low);
        if (ds) send_bit(~s2_low);
    endtask

    initial begin
        reset = 1'b1; rx = 1'b1; sample_tick = 1'b0;
        data_bits_count = 2'd3; parity_type = 2'd0; double_stop_bits = 1'b0;
        repeat (4) @(negedge clk);
        chk("reset_dout", {24'd0, dout}, 32'd0);
        chk("reset_valid", {31'd0, valid}, 32'd0);
        chk("reset_flags", {30'd0, parity_err, frame_err}, 32'd0);
        reset = 1'b0;
        idle(4);

        // 8N1 0xA5 with latency pinned at 151 ticks after detection
        send_frame(8'hA5, 8, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        chk("a5_dout", {24'd0, dout}, 32'hA5);
        chk("a5_latency", dut_valid_tick - last_d0, 32'd151);
        idle(3);

        // 7E1 good then bad parity
        send_frame(8'h55, 7, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        chk("7e1_good", {23'd0, dout, parity_err}, {23'd0, 8'h55, 1'b0});
        idle(2);
        send_frame(8'h55, 7, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        chk("7e1_bad", {23'd0, dout, parity_err}, {23'd0, 8'h55, 1'b1});
        idle(2);

        // 5O2 back-to-back
        send_frame(8'h1F, 5, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        chk("5o2_first", {22'd0, dout, parity_err, frame_err}, {22'd0, 8'h1F, 2'b00});
        send_frame(8'h00, 5, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        chk("5o2_second", {22'd0, dout, parity_err, frame_err}, {22'd0, 8'h00, 2'b00});
        idle(2);

        // framing error followed by a 40-bit break, then recovery
        send_frame(8'h3C, 8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        chk("frame_err_3c", {23'd0, dout, frame_err}, {23'd0, 8'h3C, 1'b1});
        rx = 1'b0;
        repeat (40 * 16) do_tick();
        idle(32);
        send_frame(8'h81, 8, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        chk("after_break", {22'd0, dout, parity_err, frame_err}, {22'd0, 8'h81, 2'b00});
        idle(2);

        // false start: 4 low ticks
        rx = 1'b0;
        repeat (4) do_tick();
        idle(20);
        send_frame(8'h42, 8, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        chk("after_false_start", {24'd0, dout}, 32'h42);
        idle(2);

        // reset mid-frame, then 0xF0
        send_frame(8'h99, 8, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2);
        idle(32);
        send_frame(8'hF0, 8, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        chk("after_reset_f0", {24'd0, dout}, 32'hF0);
        idle(2);

        // config change mid-frame keeps the latched 8-bit length
        send_frame(8'hB7, 8, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        chk("cfg_latched", {24'd0, dout}, 32'hB7);
        idle(2);

        // randomized frames
        for (int k = 0; k < 30; k++) begin
            logic s1l, s2l;
            s1l = ($urandom_range(0, 5) == 0);
            s2l = ($urandom_range(0, 5) == 0);
            send_frame(8'($urandom), $urandom_range(5, 8), 2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), s1l, s2l, 0);
            idle((s1l || s2l) ? $urandom_range(2, 20) : $urandom_range(0, 20));
        end

        idle(40);
        chk("queue_empty", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
